hacd_cfg_regs: RTL and testbench

HACD_CFG_REGS -- requirements
Module: hacd_cfg_regs

---
 rtl/hacd_pkg.sv | 60 ++++++
 rtl/hacd_cfg_regs_if.sv | 16 +
 rtl/hacd_sat_cnt.sv | 34 +++
 rtl/hacd_cfg_regs.sv | 207 ++++++++++++++++++++
 tb/tb_hacd_cfg_regs.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hacd_pkg.sv
// rtl/hacd_pkg.sv - shared types, register map and helpers for the HACD config block
//
// Purpose: register-bus request/response structs, register byte offsets, field
//          bit positions, parameter defaults and the byte-strobe merge helper.
// Ports:   none (package).

package hacd_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_intf_req_a32_d32;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
    } reg_intf_resp_d32;

    localparam int unsigned BusyCyclesDefault = 4;
    localparam logic [31:0] HacdIdDefault     = 32'h4841_4344;

    // Register byte offsets; only addr[7:2] is decoded, addr[31:8] must be zero.
    localparam logic [7:0] OffCtrl      = 8'h00;
    localparam logic [7:0] OffStatus    = 8'h04;
    localparam logic [7:0] OffIntStatus = 8'h08;
    localparam logic [7:0] OffIntEnable = 8'h0C;
    localparam logic [7:0] OffLowWmark  = 8'h10;
    localparam logic [7:0] OffHighWmark = 8'h14;
    localparam logic [7:0] OffFreePages = 8'h18;
    localparam logic [7:0] OffInflCnt   = 8'h1C;
    localparam logic [7:0] OffDeflCnt   = 8'h20;
    localparam logic [7:0] OffScratch   = 8'h24;
    localparam logic [7:0] OffId        = 8'h28;

    // Field bit positions
    localparam int CtrlEnableBit  = 0;
    localparam int CtrlSoftRstBit = 1;
    localparam int CtrlModeLsb    = 2;
    localparam int StatusBusyBit  = 0;
    localparam int StatusOomBit   = 1;
    localparam int IntInflBit     = 0;
    localparam int IntDeflBit     = 1;
    localparam int IntOomBit      = 2;

    // Merge new_val into old_val one byte at a time under the write strobes.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/hacd_cfg_regs_if.sv
// rtl/hacd_cfg_regs_if.sv - register bus bundle for the HACD config block
//
// Purpose: carries one register request and its response between a bus
//          master and the hacd_cfg_regs slave.
// Signals: req  - valid/write/addr/wdata/wstrb from the master
//          resp - ready/rdata from the slave

interface hacd_cfg_regs_if;
    import hacd_pkg::*;

    reg_intf_req_a32_d32 req;
    reg_intf_resp_d32    resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/hacd_sat_cnt.sv
// rtl/hacd_sat_cnt.sv - 32-bit saturating event counter with clear
//
// Purpose: counts single-cycle events, sticking at all-ones; a clear that
//          coincides with an event leaves the count at 1.
// Ports:   clk_i, rst_ni (async active-low), inc_i event, clr_i clear,
//          cnt_o current count.

module hacd_sat_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {31'b0, inc_i};
        end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hacd_cfg_regs.sv
// rtl/hacd_cfg_regs.sv - HACD configuration/status register block
//
// Purpose: register file for the HACD core: control, status, interrupts,
//          watermarks, event counters, scratch and ID, with a soft-reset
//          busy window during which requests are stalled.
// Ports:   cfg_clk_i / cfg_rst_ni  clock and async active-low reset
//          req_i / resp_o          register request and response
//          free_pages_i            free-page count from the core
//          infl/defl/oom_evt_i     single-cycle event pulses
//          enable_o, mode_o        CTRL fields
//          soft_rst_o              one-cycle soft-reset pulse
//          infl_req_o, defl_req_o  registered watermark requests
//          infl/defl_interrupt     registered level interrupts

module hacd_cfg_regs
    import hacd_pkg::*;
#(
    parameter logic [31:0] HacdId     = HacdIdDefault,
    parameter int unsigned BusyCycles = BusyCyclesDefault
) (
    input  logic                cfg_clk_i,
    input  logic                cfg_rst_ni,
    input  reg_intf_req_a32_d32 req_i,
    output reg_intf_resp_d32    resp_o,
    input  logic [31:0]         free_pages_i,
    input  logic                infl_evt_i,
    input  logic                defl_evt_i,
    input  logic                oom_evt_i,
    output logic                enable_o,
    output logic [1:0]          mode_o,
    output logic                soft_rst_o,
    output logic                infl_req_o,
    output logic                defl_req_o,
    output logic                infl_interrupt,
    output logic                defl_interrupt
);

    localparam int unsigned BusyW = (BusyCycles > 1) ? $clog2(BusyCycles + 1) : 1;

    logic             enable_q, enable_d;
    logic [1:0]       mode_q, mode_d;
    logic             soft_rst_q, soft_rst_d;
    logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
    logic             oom_seen_q, oom_seen_d;
    logic [2:0]       int_status_q, int_status_d;
    logic [2:0]       int_enable_q, int_enable_d;
    logic [31:0]      low_wmark_q, low_wmark_d;
    logic [31:0]      high_wmark_q, high_wmark_d;
    logic [31:0]      scratch_q, scratch_d;
    logic             infl_req_q, infl_req_d;
    logic             defl_req_q, defl_req_d;
    logic             infl_irq_q, infl_irq_d;
    logic             defl_irq_q, defl_irq_d;
    // Low for the first cycle after reset release so an event landing on the
    // deassertion edge is discarded.
    logic             armed_q, armed_d;

    logic        busy, hit, wr_en;
    logic [7:0]  off;
    logic        infl_evt, defl_evt, oom_evt;
    logic [31:0] infl_cnt, defl_cnt;
    logic [31:0] rdata;
    logic        unused_addr_lsbs;

    assign busy  = (busy_cnt_q != '0);
    assign hit   = (req_i.addr[31:8] == 24'h0);
    assign off   = {req_i.addr[7:2], 2'b00};
    assign wr_en = req_i.valid && req_i.write && !busy && hit;
    assign unused_addr_lsbs = ^req_i.addr[1:0];

    assign infl_evt = infl_evt_i && armed_q;
    assign defl_evt = defl_evt_i && armed_q;
    assign oom_evt  = oom_evt_i  && armed_q;

    always_comb begin
        enable_d     = enable_q;
        mode_d       = mode_q;
        soft_rst_d   = 1'b0;
        busy_cnt_d   = busy ? busy_cnt_q - 1'b1 : busy_cnt_q;
        oom_seen_d   = oom_seen_q | oom_evt;
        int_status_d = int_status_q;
        int_enable_d = int_enable_q;
        low_wmark_d  = low_wmark_q;
        high_wmark_d = high_wmark_q;
        scratch_d    = scratch_q;
        armed_d      = 1'b1;

        if (wr_en && (off == OffCtrl) && req_i.wstrb[0]) begin
            enable_d = req_i.wdata[CtrlEnableBit];
            mode_d   = req_i.wdata[CtrlModeLsb +: 2];
            if (req_i.wdata[CtrlSoftRstBit]) begin
                soft_rst_d = 1'b1;
                busy_cnt_d = BusyW'(BusyCycles);
            end
        end

        // Clear first, then OR in new events so a coincident set wins.
        if (wr_en && (off == OffIntStatus) && req_i.wstrb[0]) begin
            int_status_d = int_status_d & ~req_i.wdata[2:0];
        end
        int_status_d[IntInflBit] = int_status_d[IntInflBit] | infl_evt;
        int_status_d[IntDeflBit] = int_status_d[IntDeflBit] | defl_evt;
        int_status_d[IntOomBit]  = int_status_d[IntOomBit]  | oom_evt;

        if (wr_en && (off == OffIntEnable) && req_i.wstrb[0]) begin
            int_enable_d = req_i.wdata[2:0];
        end
        if (wr_en && (off == OffLowWmark)) begin
            low_wmark_d = apply_wstrb(low_wmark_q, req_i.wdata, req_i.wstrb);
        end
        if (wr_en && (off == OffHighWmark)) begin
            high_wmark_d = apply_wstrb(high_wmark_q, req_i.wdata, req_i.wstrb);
        end
        if (wr_en && (off == OffScratch)) begin
            scratch_d = apply_wstrb(scratch_q, req_i.wdata, req_i.wstrb);
        end

        infl_req_d = enable_q && (free_pages_i < low_wmark_q);
        defl_req_d = enable_q && (free_pages_i > high_wmark_q);
        infl_irq_d = int_status_q[IntInflBit] & int_enable_q[IntInflBit];
        defl_irq_d = |(int_status_q[IntOomBit:IntDeflBit] & int_enable_q[IntOomBit:IntDeflBit]);
    end

    always_ff @(posedge cfg_clk_i or negedge cfg_rst_ni) begin
        if (!cfg_rst_ni) begin
            enable_q     <= 1'b0;
            mode_q       <= 2'b00;
            soft_rst_q   <= 1'b0;
            busy_cnt_q   <= '0;
            oom_seen_q   <= 1'b0;
            int_status_q <= '0;
            int_enable_q <= '0;
            low_wmark_q  <= '0;
            high_wmark_q <= '0;
            scratch_q    <= '0;
            infl_req_q   <= 1'b0;
            defl_req_q   <= 1'b0;
            infl_irq_q   <= 1'b0;
            defl_irq_q   <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            soft_rst_q   <= soft_rst_d;
            busy_cnt_q   <= busy_cnt_d;
            oom_seen_q   <= oom_seen_d;
            int_status_q <= int_status_d;
            int_enable_q <= int_enable_d;
            low_wmark_q  <= low_wmark_d;
            high_wmark_q <= high_wmark_d;
            scratch_q    <= scratch_d;
            infl_req_q   <= infl_req_d;
            defl_req_q   <= defl_req_d;
            infl_irq_q   <= infl_irq_d;
            defl_irq_q   <= defl_irq_d;
            armed_q      <= armed_d;
        end
    end

    // Any accepted write to a counter offset clears it, regardless of strobes.
    hacd_sat_cnt u_infl_cnt (
        .clk_i  (cfg_clk_i),
        .rst_ni (cfg_rst_ni),
        .inc_i  (infl_evt),
        .clr_i  (wr_en && (off == OffInflCnt)),
        .cnt_o  (infl_cnt)
    );

    hacd_sat_cnt u_defl_cnt (
        .clk_i  (cfg_clk_i),
        .rst_ni (cfg_rst_ni),
        .inc_i  (defl_evt),
        .clr_i  (wr_en && (off == OffDeflCnt)),
        .cnt_o  (defl_cnt)
    );

    always_comb begin
        rdata = '0;
        if (req_i.valid && hit) begin
            case (off)
                OffCtrl:      rdata = {28'h0, mode_q, 1'b0, enable_q};
                OffStatus:    rdata = {30'h0, oom_seen_q, busy};
                OffIntStatus: rdata = {29'h0, int_status_q};
                OffIntEnable: rdata = {29'h0, int_enable_q};
                OffLowWmark:  rdata = low_wmark_q;
                OffHighWmark: rdata = high_wmark_q;
                OffFreePages: rdata = free_pages_i;
                OffInflCnt:   rdata = infl_cnt;
                OffDeflCnt:   rdata = defl_cnt;
                OffScratch:   rdata = scratch_q;
                OffId:        rdata = HacdId;
                default:      rdata = '0;
            endcase
        end
    end

    assign resp_o.ready   = !busy;
    assign resp_o.rdata   = rdata;
    assign enable_o       = enable_q;
    assign mode_o         = mode_q;
    assign soft_rst_o     = soft_rst_q;
    assign infl_req_o     = infl_req_q;
    assign defl_req_o     = defl_req_q;
    assign infl_interrupt = infl_irq_q;
    assign defl_interrupt = defl_irq_q;

endmodule

// File: tb/tb_hacd_cfg_regs.sv
// tb/tb_hacd_cfg_regs.sv - directed self-checking bench for hacd_cfg_regs

module tb_hacd_cfg_regs;
    import hacd_pkg::*;

    logic        cfg_clk;
    logic        cfg_rst_n;
    logic [31:0] free_pages;
    logic        infl_evt, defl_evt, oom_evt;
    logic        enable, soft_rst, infl_req, defl_req, infl_irq, defl_irq;
    logic [1:0]  mode;
    int          checks = 0;
    int          errors = 0;

    hacd_cfg_regs_if bus ();

    hacd_cfg_regs dut (
        .cfg_clk_i      (cfg_clk),
        .cfg_rst_ni     (cfg_rst_n),
        .req_i          (bus.req),
        .resp_o         (bus.resp),
        .free_pages_i   (free_pages),
        .infl_evt_i     (infl_evt),
        .defl_evt_i     (defl_evt),
        .oom_evt_i      (oom_evt),
        .enable_o       (enable),
        .mode_o         (mode),
        .soft_rst_o     (soft_rst),
        .infl_req_o     (infl_req),
        .defl_req_o     (defl_req),
        .infl_interrupt (infl_irq),
        .defl_interrupt (defl_irq)
    );

    initial cfg_clk = 1'b0;
    always #5 cfg_clk = ~cfg_clk;

    // Called at a negedge with ready high; returns at the following negedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.req.valid = 1'b1; bus.req.write = 1'b1;
        bus.req.addr  = a;    bus.req.wdata = d; bus.req.wstrb = s;
        @(posedge cfg_clk); @(negedge cfg_clk);
        bus.req.valid = 1'b0; bus.req.write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.req.valid = 1'b1; bus.req.write = 1'b0; bus.req.addr = a;
        #1 d = bus.resp.rdata;
        bus.req.valid = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] got;
        bus_read(a, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic pulse(input int which);
        if (which == 0) infl_evt = 1'b1;
        if (which == 1) defl_evt = 1'b1;
        if (which == 2) oom_evt  = 1'b1;
        @(posedge cfg_clk); @(negedge cfg_clk);
        infl_evt = 1'b0; defl_evt = 1'b0; oom_evt = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge cfg_clk);
        checks++;
        if ({bus.resp.ready, soft_rst, enable, infl_irq, defl_irq, infl_req, defl_req} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 1000000",
                     {bus.resp.ready, soft_rst, enable, infl_irq, defl_irq, infl_req, defl_req});
        end
        // Event coincident with reset release must be dropped.
        infl_evt = 1'b1;
        cfg_rst_n = 1'b1;
        @(posedge cfg_clk); @(negedge cfg_clk);
        infl_evt = 1'b0;
        check_read("reset_evt_int_status", 32'h08, 32'h0);
        check_read("reset_evt_infl_cnt", 32'h1C, 32'h0);
        check_read("reset_ctrl", 32'h00, 32'h0);
        check_read("reset_scratch", 32'h24, 32'h0);
    endtask

    task automatic test_scratch_strobes;
        bus_write(32'h24, 32'hDEADBEEF, 4'b0101);
        check_read("scratch_wstrb_0101", 32'h24, 32'h00AD00EF);
        bus_write(32'h24, 32'h12345678, 4'b1010);
        check_read("scratch_wstrb_1010", 32'h24, 32'h12AD56EF);
    endtask

    task automatic test_decode;
        check_read("id", 32'h28, 32'h4841_4344);
        check_read("unmapped_100", 32'h100, 32'h0);
        check_read("unmapped_2c", 32'h2C, 32'h0);
        bus_write(32'h100, 32'hFFFF_FFFF, 4'hF);
        check_read("unmapped_write_no_alias", 32'h00, 32'h0);
        bus.req.valid = 1'b0; bus.req.addr = 32'h28;
        #1;
        checks++;
        if (bus.resp.rdata !== 32'h0) begin
            errors++;
            $display("FAIL rdata_idle: got %08h expected 00000000", bus.resp.rdata);
        end
    endtask

    task automatic test_interrupts;
        bus_write(32'h0C, 32'h1, 4'hF);
        infl_evt = 1'b1;
        @(posedge cfg_clk); @(negedge cfg_clk);
        infl_evt = 1'b0;
        checks++;
        if (infl_irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", infl_irq); end
        @(posedge cfg_clk); @(negedge cfg_clk);
        checks++;
        if (infl_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", infl_irq); end
        bus_write(32'h08, 32'h1, 4'hF);
        @(posedge cfg_clk); @(negedge cfg_clk);
        checks++;
        if (infl_irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", infl_irq); end
        // Set and w1c clear in the same cycle: set wins.
        infl_evt = 1'b1;
        bus_write(32'h08, 32'h1, 4'hF);
        infl_evt = 1'b0;
        check_read("w1c_set_wins", 32'h08, 32'h1);
        check_read("infl_cnt_two", 32'h1C, 32'h2);
        pulse(2);
        check_read("status_oom_seen", 32'h04, 32'h2);
        check_read("int_status_oom", 32'h08, 32'h5);
        bus_write(32'h0C, 32'h4, 4'hF);
        @(posedge cfg_clk); @(negedge cfg_clk);
        checks++;
        if ({infl_irq, defl_irq} !== 2'b01) begin
            errors++; $display("FAIL defl_irq_oom: got %b expected 01", {infl_irq, defl_irq});
        end
        bus_write(32'h08, 32'h7, 4'hF);
        check_read("int_status_cleared", 32'h08, 32'h0);
    endtask

    task automatic test_watermarks;
        bus_write(32'h10, 32'd10, 4'hF);
        bus_write(32'h00, 32'h1, 4'hF);
        free_pages = 32'd11;
        @(posedge cfg_clk); @(negedge cfg_clk);
        checks++;
        if (infl_req !== 1'b0) begin errors++; $display("FAIL infl_req_11: got %b expected 0", infl_req); end
        free_pages = 32'd10;
        @(posedge cfg_clk); @(negedge cfg_clk);
        checks++;
        if (infl_req !== 1'b0) begin errors++; $display("FAIL infl_req_10: got %b expected 0", infl_req); end
        free_pages = 32'd9;
        #1;
        checks++;
        if (infl_req !== 1'b0) begin errors++; $display("FAIL infl_req_9_same_cycle: got %b expected 0", infl_req); end
        @(posedge cfg_clk); @(negedge cfg_clk);
        checks++;
        if (infl_req !== 1'b1) begin errors++; $display("FAIL infl_req_9: got %b expected 1", infl_req); end
        checks++;
        if (defl_req !== 1'b1) begin errors++; $display("FAIL defl_req_high0: got %b expected 1", defl_req); end
        check_read("free_pages", 32'h18, 32'd9);
        bus_write(32'h14, 32'd9, 4'hF);
        @(posedge cfg_clk); @(negedge cfg_clk);
        checks++;
        if (defl_req !== 1'b0) begin errors++; $display("FAIL defl_req_equal: got %b expected 0", defl_req); end
        free_pages = 32'd0;
    endtask

    task automatic test_soft_reset;
        int low_cycles;
        int pulses;
        int stale;
        bus_write(32'h00, 32'h3, 4'hF);
        pulses = soft_rst ? 1 : 0;
        low_cycles = 0;
        stale = 0;
        bus.req.valid = 1'b1; bus.req.write = 1'b1;
        bus.req.addr = 32'h24; bus.req.wdata = 32'hCAFEF00D; bus.req.wstrb = 4'hF;
        for (int i = 0; i < 20; i++) begin
            if (bus.resp.ready) break;
            low_cycles++;
            bus.req.write = 1'b0;
            #1 if (bus.resp.rdata !== 32'h12AD56EF) stale++;
            bus.req.write = 1'b1;
            @(posedge cfg_clk); @(negedge cfg_clk);
            if (soft_rst) pulses++;
        end
        checks++;
        if (!bus.resp.ready) begin errors++; $display("FAIL busy_timeout: ready still %b expected 1", bus.resp.ready); end
        checks++;
        if (low_cycles != 4) begin errors++; $display("FAIL busy_cycles: got %0d expected 4", low_cycles); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL soft_rst_pulses: got %0d expected 1", pulses); end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL write_during_busy: %0d cycles altered expected 0", stale); end
        @(posedge cfg_clk); @(negedge cfg_clk);
        bus.req.valid = 1'b0; bus.req.write = 1'b0;
        check_read("scratch_after_busy", 32'h24, 32'hCAFEF00D);
        check_read("ctrl_soft_rst_reads0", 32'h00, 32'h1);
    endtask

    task automatic test_counters;
        force dut.u_infl_cnt.cnt_q = 32'hFFFF_FFFD;
        @(posedge cfg_clk); @(negedge cfg_clk);
        release dut.u_infl_cnt.cnt_q;
        check_read("infl_cnt_preload", 32'h1C, 32'hFFFF_FFFD);
        pulse(0);
        check_read("infl_cnt_fffe", 32'h1C, 32'hFFFF_FFFE);
        pulse(0);
        pulse(0);
        check_read("infl_cnt_saturate", 32'h1C, 32'hFFFF_FFFF);
        infl_evt = 1'b1;
        bus_write(32'h1C, 32'h0, 4'hF);
        infl_evt = 1'b0;
        check_read("infl_cnt_clr_inc", 32'h1C, 32'h1);
        pulse(1);
        pulse(1);
        check_read("defl_cnt_two", 32'h20, 32'h2);
        bus_write(32'h20, 32'h0, 4'h0);
        check_read("defl_cnt_clr_nostrb", 32'h20, 32'h0);
    endtask

    task automatic test_async_reset;
        bus_write(32'h00, 32'h2, 4'hF);
        checks++;
        if (bus.resp.ready !== 1'b0) begin errors++; $display("FAIL busy_before_reset: got %b expected 0", bus.resp.ready); end
        #2 cfg_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.resp.ready, soft_rst, enable} !== 3'b100) begin
            errors++; $display("FAIL async_reset: got %b expected 100", {bus.resp.ready, soft_rst, enable});
        end
        @(negedge cfg_clk);
        cfg_rst_n = 1'b1;
        @(negedge cfg_clk);
        check_read("scratch_after_reset", 32'h24, 32'h0);
    endtask

    initial begin
        cfg_rst_n  = 1'b0;
        free_pages = 32'd0;
        infl_evt   = 1'b0;
        defl_evt   = 1'b0;
        oom_evt    = 1'b0;
        bus.req    = '0;
        test_reset();
        test_scratch_strobes();
        test_decode();
        test_interrupts();
        test_watermarks();
        test_soft_reset();
        test_counters();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
